// File: rtl/alu_op_arbiter.sv
// ============================================================================
//  Module   : alu_op_arbiter
//  Brief    : Round-robin sharing of one ALU between two requesters, with a
//             start/done handshake, timeout watchdog and tagged response.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_arbiter #(
   parameter int W       = 16,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         alu_start,
   output logic [3:0]   alu_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic         alu_done,
   input  logic [W-1:0] alu_result,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic         rsp_err,
   output logic         busy
);

   localparam int c_TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic              r_rrPtr;
   logic              r_id;
   logic [3:0]        r_op;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic [W-1:0]      r_rspData;
   logic              r_rspErr;
   logic [c_TW-1:0]   r_timer;
   logic              w_grant0;
   logic              w_grant1;
   logic              w_timeout;

   assign w_timeout = (r_timer == c_TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_grant0    = 1'b0;
      w_grant1    = 1'b0;
      alu_start   = 1'b0;
      alu_op      = '0;
      alu_a       = '0;
      alu_b       = '0;
      rsp_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            // rr pointer only breaks ties; a lone requester always wins
            if (req0_valid && (!req1_valid || !r_rrPtr)) begin
               w_grant0 = 1'b1;
            end else if (req1_valid) begin
               w_grant1 = 1'b1;
            end
            if (w_grant0 || w_grant1) begin
               w_nextState = S_ISSUE;
            end
         end
         S_ISSUE: begin
            alu_start   = 1'b1;
            alu_op      = r_op;
            alu_a       = r_a;
            alu_b       = r_b;
            w_nextState = S_WAIT;
         end
         S_WAIT: begin
            alu_op = r_op;
            alu_a  = r_a;
            alu_b  = r_b;
            if (alu_done || w_timeout) begin
               w_nextState = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_nextState = S_IDLE;
            end
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Readys are held low while reset is asserted so every output reads 0
   assign req0_ready = w_grant0 & rst_n;
   assign req1_ready = w_grant1 & rst_n;
   assign rsp_id     = r_id;
   assign rsp_data   = r_rspData;
   assign rsp_err    = r_rspErr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rrPtr   <= 1'b0;
         r_id      <= 1'b0;
         r_op      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_rspData <= '0;
         r_rspErr  <= 1'b0;
         r_timer   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant0 || w_grant1) begin
                  r_id    <= w_grant1;
                  r_rrPtr <= ~w_grant1;
                  r_op    <= w_grant1 ? req1_op : req0_op;
                  r_a     <= w_grant1 ? req1_a  : req0_a;
                  r_b     <= w_grant1 ? req1_b  : req0_b;
               end
            end
            S_ISSUE: begin
               r_timer <= '0;
            end
            S_WAIT: begin
               // done has priority over a coincident timeout
               if (alu_done) begin
                  r_rspData <= alu_result;
                  r_rspErr  <= 1'b0;
               end else if (w_timeout) begin
                  r_rspData <= '0;
                  r_rspErr  <= 1'b1;
               end else begin
                  r_timer <= r_timer + c_TW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_arbiter.sv
// ============================================================================
//  Module   : tb_alu_op_arbiter
//  Brief    : Self-checking bench for alu_op_arbiter with a behavioural ALU
//             and a round-robin/latency reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_arbiter;

   localparam int W  = 16;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [3:0]   req0_op = '0, req1_op = '0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         alu_start;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_a, alu_b;
   logic         alu_done = 1'b0;
   logic [W-1:0] alu_result = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic         rsp_id;
   logic [W-1:0] rsp_data;
   logic         rsp_err;
   logic         busy;

   alu_op_arbiter #(.W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_done(alu_done), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   int           nChecks = 0;
   int           nErrors = 0;
   int           rrModel = 0;
   int           aluLat = 2;
   bit           aluMute = 1'b0;
   bit           useFixed = 1'b0;
   bit           forceDone = 1'b0;
   logic [W-1:0] fixedVal = '0;
   bit           dirEn = 1'b0;
   logic [3:0]   dirOp = '0;
   logic [W-1:0] dirA = '0, dirB = '0;

   function automatic logic [W-1:0] aluFn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      return (a + b) ^ {4{op}};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural ALU: done arrives aluLat cycles after the start cycle
   initial begin
      int           cnt;
      logic [W-1:0] pend;
      cnt  = -1;
      pend = '0;
      forever begin
         @(negedge clk);
         alu_done = forceDone;
         if (forceDone) alu_result = 16'hDEAD;
         if (cnt == 0) begin
            alu_done   = 1'b1;
            alu_result = pend;
            cnt        = -1;
         end else if (cnt > 0) begin
            cnt--;
         end
         if (alu_start && !aluMute) begin
            cnt  = aluLat - 1;
            pend = useFixed ? fixedVal : aluFn(alu_op, alu_a, alu_b);
         end
         if (!rst_n) cnt = -1;
      end
   end

   // Starts and ends at a negedge with the DUT idle
   task automatic runOp(input bit v0, input bit v1, input int lat, input bit mute,
                        input int holdCycles, input string tag);
      logic [3:0]   op [2];
      logic [W-1:0] a [2];
      logic [W-1:0] b [2];
      int           win, cnt, starts, expLat;
      bit           held, stable;
      logic [W-1:0] expData;
      for (int i = 0; i < 2; i++) begin
         op[i] = dirEn ? dirOp : 4'($urandom);
         a[i]  = dirEn ? dirA  : W'($urandom);
         b[i]  = dirEn ? dirB  : W'($urandom);
      end
      req0_op = op[0]; req0_a = a[0]; req0_b = b[0]; req0_valid = v0;
      req1_op = op[1]; req1_a = a[1]; req1_b = b[1]; req1_valid = v1;
      aluLat  = lat;
      aluMute = mute;
      win     = (v0 && v1) ? rrModel : (v0 ? 0 : 1);
      expData = mute ? '0 : (useFixed ? fixedVal : aluFn(op[win], a[win], b[win]));
      expLat  = mute ? TO + 1 : lat + 1;
      #1;
      chk({tag, "_ready0"}, req0_ready, win == 0);
      chk({tag, "_ready1"}, req1_ready, win == 1);
      @(negedge clk);
      rrModel = 1 - win;
      chk({tag, "_issue"}, {alu_start, busy, alu_op, alu_a, alu_b},
          {2'b11, op[win], a[win], b[win]});
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = W'($urandom); req1_a = W'($urandom); req0_op = 4'($urandom);
      cnt = 0; starts = 0; held = 1'b1;
      while (cnt < 60) begin
         @(negedge clk);
         cnt++;
         if (rsp_valid) break;
         if (alu_start) starts++;
         if (alu_op !== op[win] || alu_a !== a[win] || alu_b !== b[win] || busy !== 1'b1)
            held = 1'b0;
      end
      chk({tag, "_latency"}, cnt, expLat);
      chk({tag, "_extra_starts"}, starts, 0);
      chk({tag, "_held"}, held, 1'b1);
      chk({tag, "_rsp"}, {rsp_id, rsp_err, rsp_data}, {1'(win), mute, expData});
      stable = 1'b1;
      if (holdCycles > 0) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
      end
      for (int k = 0; k < holdCycles; k++) begin
         #1;
         if (req0_ready || req1_ready || !rsp_valid || alu_start || !busy ||
             rsp_data !== expData || rsp_id !== 1'(win) || rsp_err !== mute)
            stable = 1'b0;
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      if (req0_ready || req1_ready) stable = 1'b0;
      chk({tag, "_resp_stable"}, stable, 1'b1);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_idle"}, {rsp_valid, busy, alu_start, alu_a}, '0);
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", nErrors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit rv0, rv1;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {alu_start, rsp_valid, busy, req0_ready, req1_ready, rsp_id,
                            rsp_err, alu_op, alu_a, alu_b, rsp_data}, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed ADD 5+3 with done two cycles after start
      dirEn = 1'b1; dirOp = 4'h0; dirA = 16'd5; dirB = 16'd3;
      runOp(1'b1, 1'b0, 2, 1'b0, 0, "add");
      dirEn = 1'b0;

      for (int i = 0; i < 6; i++) runOp(1'b1, 1'b1, 1 + i % 3, 1'b0, 0, "rr");

      runOp(1'b1, 1'b0, 1, 1'b1, 0, "timeout");

      useFixed = 1'b1; fixedVal = 16'hBEEF;
      runOp(1'b0, 1'b1, TO, 1'b0, 0, "done_at_timeout");
      useFixed = 1'b0;

      forceDone = 1'b1;
      @(negedge clk);
      forceDone = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("stray_done", {busy, rsp_valid, alu_start}, '0);

      runOp(1'b1, 1'b1, 3, 1'b0, 5, "resp_hold");

      for (int i = 0; i < 10; i++) begin
         rv0 = 1'($urandom_range(0, 1));
         rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
         runOp(rv0, rv1, $urandom_range(1, 6), 1'b0, $urandom_range(0, 2), "rand");
      end

      // Reset during WAIT after a grant to requester 1
      req1_valid = 1'b1; req1_op = 4'hA; req1_a = 16'h1234; req1_b = 16'h0F0F;
      aluMute = 1'b1;
      @(negedge clk);
      req1_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_reset_busy", {busy, alu_op}, {1'b1, 4'hA});
      req0_valid = 1'b1; req1_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", {alu_start, rsp_valid, busy, req0_ready, req1_ready, rsp_id,
                          rsp_err, alu_op, alu_a, alu_b, rsp_data}, '0);
      rrModel = 0;
      aluMute = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      runOp(1'b1, 1'b1, 2, 1'b0, 0, "after_reset");

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

`default_nettype wire
